// File: rtl/csrbrg_rmw.sv
// Wishbone classic slave to CSR master bridge. Partial-byte writes become a
// read-modify-write because CSR slaves have no byte enables.
module csrbrg_rmw #(
  parameter int unsigned csr_aw = 14
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic [2:0]        wb_cti_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic [csr_aw-1:0] csr_a,
  output logic              csr_we,
  output logic [31:0]       csr_do,
  input  logic [31:0]       csr_di
);

  typedef enum logic [2:0] {StIdle, StRd1, StRd2, StRmw1, StRmw2} state_e;

  state_e      state_q;
  logic [31:0] sel_mask;
  logic [31:0] merged;
  logic        accept;

  // Burst type and byte offset are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{wb_cti_i, wb_adr_i[31:csr_aw+2], wb_adr_i[1:0]};

  assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o;

  always_comb begin
    sel_mask = '0;
    for (int b = 0; b < 4; b++) begin
      sel_mask[8*b +: 8] = {8{wb_sel_i[b]}};
    end
    merged = (wb_dat_i & sel_mask) | (csr_di & ~sel_mask);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      csr_a    <= '0;
      csr_we   <= 1'b0;
      csr_do   <= '0;
    end else begin
      csr_we   <= 1'b0;
      wb_ack_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (!wb_we_i) begin
              csr_a   <= wb_adr_i[csr_aw+1:2];
              state_q <= StRd1;
            end else if (wb_sel_i == 4'hF) begin
              csr_a    <= wb_adr_i[csr_aw+1:2];
              csr_do   <= wb_dat_i;
              csr_we   <= 1'b1;
              wb_ack_o <= 1'b1;
            end else if (wb_sel_i == 4'h0) begin
              wb_ack_o <= 1'b1;
            end else begin
              csr_a   <= wb_adr_i[csr_aw+1:2];
              state_q <= StRmw1;
            end
          end
        end
        StRd1: state_q <= wb_cyc_i ? StRd2 : StIdle;
        StRd2: begin
          state_q <= StIdle;
          if (wb_cyc_i) begin
            wb_dat_o <= csr_di;
            wb_ack_o <= 1'b1;
          end
        end
        StRmw1: state_q <= wb_cyc_i ? StRmw2 : StIdle;
        StRmw2: begin
          state_q <= StIdle;
          // csr_di now holds the old register value; master still holds dat/sel.
          if (wb_cyc_i) begin
            csr_do   <= merged;
            csr_we   <= 1'b1;
            wb_ack_o <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_csrbrg_rmw.sv
// Self-checking bench for csrbrg_rmw: directed scenarios plus randomized
// accesses against a byte-merge reference model of the CSR register file.
module tb_csrbrg_rmw;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic [2:0]  wb_cti_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_ack_o;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_do, csr_di;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  csrbrg_rmw #(.csr_aw(14)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_cti_i (wb_cti_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_ack_o (wb_ack_o),
    .csr_a    (csr_a),
    .csr_we   (csr_we),
    .csr_do   (csr_do),
    .csr_di   (csr_di)
  );

  function automatic logic [31:0] init_val(input logic [13:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
  endfunction

  // CSR slave: registered read data, write on csr_we; optional preload port.
  logic [31:0] mem [0:16383];
  bit          valid [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_a = '0;
  logic [31:0] pl_d = '0;

  always @(posedge sys_clk) begin
    if (pl_en) begin
      mem[pl_a]   <= pl_d;
      valid[pl_a] <= 1'b1;
    end else if (csr_we) begin
      mem[csr_a]   <= csr_do;
      valid[csr_a] <= 1'b1;
    end
    csr_di <= valid[csr_a] ? mem[csr_a] : init_val(csr_a);
  end

  // Reference model of the register file contents.
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input logic [13:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge sys_clk);
    pl_en = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  // One Wishbone classic access; master holds stb through the edge after ack.
  // lat = edges from acceptance edge (1 = first edge) to ack, -1 on timeout.
  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int lat, output int acks,
                        output int wes, output int we_cyc, output logic [31:0] do_seen,
                        output logic [13:0] a_seen, output logic [31:0] rd);
    lat = -1; acks = 0; wes = 0; we_cyc = -1; do_seen = 'x; a_seen = 'x; rd = 'x;
    @(negedge sys_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    wb_sel_i = sel; wb_cti_i = 3'($urandom());
    for (int c = 1; c <= 10; c++) begin
      @(posedge sys_clk); #1;
      if (wb_ack_o) begin
        acks++;
        if (lat < 0) begin lat = c; rd = wb_dat_o; end
      end
      if (csr_we) begin wes++; we_cyc = c; do_seen = csr_do; a_seen = csr_a; end
      if (lat >= 0 && c == lat + 1) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      if (lat >= 0 && c == lat + 2) break;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", wb_dat_o); end
    checks++; if (csr_a !== 14'h0) begin errors++; $display("FAIL reset_csr_a got=%h exp=0", csr_a); end
    checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL reset_csr_we got=%b exp=0", csr_we); end
    checks++; if (csr_do !== 32'h0) begin errors++; $display("FAIL reset_csr_do got=%h exp=0", csr_do); end
    @(negedge sys_clk); sys_rst_n = 1'b1;
  endtask

  task automatic test_full_write;
    int lat, acks, wes, wc; logic [31:0] dos, rd; logic [13:0] as;
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat, acks, wes, wc, dos, as, rd);
    ref_mem[4] = 32'hDEAD_BEEF;
    checks++; if (lat !== 1) begin errors++; $display("FAIL full_lat got=%0d exp=1", lat); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL full_acks got=%0d exp=1", acks); end
    checks++; if (wes !== 1) begin errors++; $display("FAIL full_we_pulses got=%0d exp=1", wes); end
    checks++; if (as !== 14'd4) begin errors++; $display("FAIL full_csr_a got=%h exp=4", as); end
    checks++; if (dos !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_csr_do got=%h exp=deadbeef", dos); end
  endtask

  task automatic test_read;
    int lat, acks, wes, wc; logic [31:0] dos, rd; logic [13:0] as;
    preload(14'd7, 32'h1234_5678);
    access(1'b0, 32'h0000_001C, 32'hFFFF_FFFF, 4'h3, lat, acks, wes, wc, dos, as, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_lat got=%0d exp=3", lat); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL read_acks got=%0d exp=1", acks); end
    checks++; if (wes !== 0) begin errors++; $display("FAIL read_we_pulses got=%0d exp=0", wes); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL read_data got=%h exp=12345678", rd); end
  endtask

  task automatic test_partial_write;
    int lat, acks, wes, wc; logic [31:0] dos, rd; logic [13:0] as;
    preload(14'd9, 32'hAABB_CCDD);
    access(1'b1, 32'h0000_0024, 32'h1122_3344, 4'b0101, lat, acks, wes, wc, dos, as, rd);
    ref_mem[9] = 32'hAA22_CC44;
    checks++; if (lat !== 3) begin errors++; $display("FAIL rmw_lat got=%0d exp=3", lat); end
    checks++; if (wes !== 1) begin errors++; $display("FAIL rmw_we_pulses got=%0d exp=1", wes); end
    checks++; if (wc !== lat) begin errors++; $display("FAIL rmw_ack_align we_cycle=%0d ack_cycle=%0d", wc, lat); end
    checks++; if (dos !== 32'hAA22_CC44) begin errors++; $display("FAIL rmw_csr_do got=%h exp=aa22cc44", dos); end
    checks++; if (as !== 14'd9) begin errors++; $display("FAIL rmw_csr_a got=%h exp=9", as); end
  endtask

  task automatic test_null_write;
    int lat, acks, wes, wc; logic [31:0] dos, rd; logic [13:0] as;
    access(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h0, lat, acks, wes, wc, dos, as, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL null_lat got=%0d exp=1", lat); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL null_acks got=%0d exp=1", acks); end
    checks++; if (wes !== 0) begin errors++; $display("FAIL null_we_pulses got=%0d exp=0", wes); end
  endtask

  task automatic test_abort;
    int lat, acks, wes, wc, bad_ack, bad_we; logic [31:0] dos, rd; logic [13:0] as;
    bad_ack = 0; bad_we = 0;
    @(negedge sys_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h0000_0024;
    wb_dat_i = 32'h5566_7788; wb_sel_i = 4'b1000;
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge sys_clk); #1;
      if (wb_ack_o) bad_ack++;
      if (csr_we) bad_we++;
    end
    checks++; if (bad_ack !== 0) begin errors++; $display("FAIL abort_ack got=%0d exp=0", bad_ack); end
    checks++; if (bad_we !== 0) begin errors++; $display("FAIL abort_we got=%0d exp=0", bad_we); end
    access(1'b0, 32'h0000_0024, 32'h0, 4'hF, lat, acks, wes, wc, dos, as, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_read_lat got=%0d exp=3", lat); end
    checks++; if (rd !== ref_rd(14'd9)) begin errors++; $display("FAIL abort_read_data got=%h exp=%h", rd, ref_rd(14'd9)); end
  endtask

  task automatic test_reset_mid;
    int lat, acks, wes, wc; logic [31:0] dos, rd; logic [13:0] as;
    @(negedge sys_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0154; wb_sel_i = 4'hF;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack got=%b exp=0", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL rstmid_dat got=%h exp=0", wb_dat_o); end
    checks++; if (csr_a !== 14'h0) begin errors++; $display("FAIL rstmid_csr_a got=%h exp=0", csr_a); end
    checks++; if (csr_do !== 32'h0) begin errors++; $display("FAIL rstmid_csr_do got=%h exp=0", csr_do); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    access(1'b1, 32'h0000_0158, 32'h0BAD_CAFE, 4'hF, lat, acks, wes, wc, dos, as, rd);
    ref_mem[86] = 32'h0BAD_CAFE;
    checks++; if (lat !== 1) begin errors++; $display("FAIL rstmid_write_lat got=%0d exp=1", lat); end
    checks++; if (wes !== 1) begin errors++; $display("FAIL rstmid_write_we got=%0d exp=1", wes); end
    checks++; if (dos !== 32'h0BAD_CAFE) begin errors++; $display("FAIL rstmid_write_do got=%h exp=0badcafe", dos); end
  endtask

  task automatic test_back_to_back;
    int ack_cyc [$];
    int i, wes;
    logic [31:0] d [4];
    i = 0; wes = 0;
    for (int k = 0; k < 4; k++) d[k] = $urandom();
    @(negedge sys_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_adr_i = 32'h0000_0080; wb_dat_i = d[0];
    for (int c = 1; c <= 20 && i < 4; c++) begin
      @(posedge sys_clk); #1;
      if (csr_we) begin
        wes++;
        checks++;
        if (csr_do !== d[i] || csr_a !== 14'(32 + i)) begin
          errors++; $display("FAIL b2b_write%0d got=%h@%h exp=%h@%h", i, csr_do, csr_a, d[i], 32 + i);
        end
      end
      if (wb_ack_o) begin
        ack_cyc.push_back(c);
        ref_mem[32 + i] = d[i];
        i++;
        if (i < 4) begin wb_adr_i = 32'(32'h80 + 4 * i); wb_dat_i = d[i]; end
        else begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checks++; if (ack_cyc.size() !== 4) begin errors++; $display("FAIL b2b_acks got=%0d exp=4", ack_cyc.size()); end
    checks++; if (wes !== 4) begin errors++; $display("FAIL b2b_we_pulses got=%0d exp=4", wes); end
    for (int k = 1; k < ack_cyc.size(); k++) begin
      checks++;
      if (ack_cyc[k] - ack_cyc[k-1] !== 2) begin
        errors++; $display("FAIL b2b_spacing%0d got=%0d exp=2", k, ack_cyc[k] - ack_cyc[k-1]);
      end
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_random;
    int lat, acks, wes, wc, exp_lat, exp_wes; logic [31:0] dos, rd, r, dat, exp_do;
    logic [13:0] as, a; logic [3:0] sel; logic we;
    for (int n = 0; n < 40; n++) begin
      r = $urandom(); dat = $urandom();
      a = 14'($urandom_range(0, 15)) + 14'h100;
      we = r[4];
      sel = (r[6:5] == 2'b00) ? 4'hF : (r[6:5] == 2'b01) ? 4'h0 : r[10:7];
      exp_do = (sel == 4'hF) ? dat : merge(ref_rd(a), dat, sel);
      exp_lat = (!we || (sel != 4'hF && sel != 4'h0)) ? 3 : 1;
      exp_wes = (we && sel != 4'h0) ? 1 : 0;
      access(we, {r[31:16], a, r[1:0]}, dat, sel, lat, acks, wes, wc, dos, as, rd);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_lat got=%0d exp=%0d", n, lat, exp_lat); end
      checks++; if (acks !== 1) begin errors++; $display("FAIL rand%0d_acks got=%0d exp=1", n, acks); end
      checks++; if (wes !== exp_wes) begin errors++; $display("FAIL rand%0d_we got=%0d exp=%0d", n, wes, exp_wes); end
      if (!we) begin
        checks++; if (rd !== ref_rd(a)) begin errors++; $display("FAIL rand%0d_rdata got=%h exp=%h", n, rd, ref_rd(a)); end
      end else if (exp_wes == 1) begin
        checks++;
        if (dos !== exp_do || as !== a) begin
          errors++; $display("FAIL rand%0d_wdata got=%h@%h exp=%h@%h", n, dos, as, exp_do, a);
        end
        ref_mem[int'(a)] = exp_do;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_read();
    test_partial_write();
    test_null_write();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
